// File: rtl/exec_step_ctrl.sv
// rtl/exec_step_ctrl.sv - processor clock-enable controller with run/step/halt control
//
// Ports:
//   clk_in       fast system clock, every flop on the rising edge
//   rst_n        asynchronous active-low reset
//   slow_clk     divided clock, sampled here as asynchronous data
//   btn_run      raw run/pause button (active-high, asynchronous)
//   btn_step     raw single-step button (active-high, asynchronous)
//   halt         halt request, synchronous to clk_in, level sensitive
//   proc_en      registered one-cycle processor enable pulse
//   state        IDLE=0, RUN=1, STEP=2, HALTED=3
//   cycle_count  number of proc_en pulses issued, saturating at all-ones
module exec_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_clk,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             halt,
  output logic             proc_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  state_t state_q;
  state_t state_d;
  logic   proc_en_d;

  // slow_clk: s1/s2 synchronize, s3 remembers the previous synced value.
  logic s1, s2, s3;
  logic tick;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slow_clk;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  // Button conditioning: index 0 is run, index 1 is step.
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {btn_step, btn_run};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic        sync1;
    logic        sync2;
    logic        db_lvl;
    logic        db_dly;
    logic        press_q;
    logic [15:0] db_cnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        sync1   <= 1'b0;
        sync2   <= 1'b0;
        db_lvl  <= 1'b0;
        db_dly  <= 1'b0;
        press_q <= 1'b0;
        db_cnt  <= 16'd0;
      end else begin
        sync1 <= btn_raw[g];
        sync2 <= sync1;
        // Any return to the accepted level restarts the stability window.
        if (sync2 == db_lvl) begin
          db_cnt <= 16'd0;
        end else if (db_cnt == DB_LAST) begin
          db_lvl <= sync2;
          db_cnt <= 16'd0;
        end else begin
          db_cnt <= db_cnt + 16'd1;
        end
        db_dly  <= db_lvl;
        // Only the debounced rising edge is an event; release is silent.
        press_q <= db_lvl & ~db_dly;
      end
    end

    assign press[g] = press_q;
  end

  always_comb begin
    state_d = state_q;
    if (halt) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        IDLE: begin
          if (press[0]) begin
            state_d = RUN;
          end else if (press[1]) begin
            state_d = STEP;
          end
        end
        RUN: begin
          if (press[0]) begin
            state_d = IDLE;
          end
        end
        STEP: begin
          if (tick) begin
            state_d = IDLE;
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  // A tick that coincides with a pause press still executes.
  assign proc_en_d = tick & ~halt & ((state_q == RUN) | (state_q == STEP));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      proc_en     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state_q <= state_d;
      proc_en <= proc_en_d;
      if (proc_en && (cycle_count != {CNT_W{1'b1}})) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_exec_step_ctrl.sv
// tb/tb_exec_step_ctrl.sv - self-checking bench for exec_step_ctrl
module tb_exec_step_ctrl;

  localparam int D = 16;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        slow_clk = 1'b0;
  logic        btn_run = 1'b0;
  logic        btn_step = 1'b0;
  logic        halt = 1'b0;
  logic        proc_en, proc_en4;
  logic [1:0]  state, state4;
  logic [15:0] cycle_count;
  logic [3:0]  cycle_count4;

  exec_step_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .slow_clk(slow_clk), .btn_run(btn_run),
    .btn_step(btn_step), .halt(halt), .proc_en(proc_en), .state(state),
    .cycle_count(cycle_count)
  );

  exec_step_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut4 (
    .clk_in(clk_in), .rst_n(rst_n), .slow_clk(slow_clk), .btn_run(btn_run),
    .btn_step(btn_step), .halt(halt), .proc_en(proc_en4), .state(state4),
    .cycle_count(cycle_count4)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: sample histories, run lengths and plain state numbers.
  int m_sh1, m_sh2, m_sh3;
  int m_bh1[2], m_bh2[2], m_db[2], m_run[2], m_r1[2], m_r2[2];
  int m_st, m_pen, m_c16, m_c4;

  bit slow_auto = 1'b0;
  int slow_half = 4;
  int slow_ctr = 0;
  int rise_cnt = 0;

  task automatic model_reset();
    m_sh1 = 0; m_sh2 = 0; m_sh3 = 0;
    for (int b = 0; b < 2; b++) begin
      m_bh1[b] = 0; m_bh2[b] = 0; m_db[b] = 0; m_run[b] = 0; m_r1[b] = 0; m_r2[b] = 0;
    end
    m_st = 0; m_pen = 0; m_c16 = 0; m_c4 = 0;
  endtask

  task automatic model_step();
    int tick, synced, new_pen, new_st;
    int rose[2];
    int pr[2];
    if (!rst_n) begin
      model_reset();
      return;
    end
    tick = (m_sh2 == 1 && m_sh3 == 0) ? 1 : 0;
    for (int b = 0; b < 2; b++) begin
      pr[b] = m_r2[b];
      synced = m_bh2[b];
      rose[b] = 0;
      if (synced != m_db[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_db[b] = synced;
          m_run[b] = 0;
          rose[b] = synced;
        end
      end else begin
        m_run[b] = 0;
      end
      m_r2[b] = m_r1[b];
      m_r1[b] = rose[b];
      m_bh2[b] = m_bh1[b];
      m_bh1[b] = (b == 0) ? int'(btn_run) : int'(btn_step);
    end
    new_pen = (tick == 1 && !halt && (m_st == 1 || m_st == 2)) ? 1 : 0;
    if (m_pen == 1 && m_c16 < 65535) m_c16++;
    if (m_pen == 1 && m_c4 < 15) m_c4++;
    if (halt) begin
      new_st = 3;
    end else begin
      case (m_st)
        0: new_st = (pr[0] == 1) ? 1 : ((pr[1] == 1) ? 2 : 0);
        1: new_st = (pr[0] == 1) ? 0 : 1;
        2: new_st = (tick == 1) ? 0 : 2;
        default: new_st = 3;
      endcase
    end
    m_st = new_st;
    m_pen = new_pen;
    m_sh3 = m_sh2;
    m_sh2 = m_sh1;
    m_sh1 = int'(slow_clk);
  endtask

  // One clock: model consumes the pre-edge inputs, bench returns at the negedge.
  task automatic cyc();
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    if (slow_auto) begin
      slow_ctr++;
      if (slow_ctr >= slow_half) begin
        slow_ctr = 0;
        slow_clk = ~slow_clk;
        if (slow_clk) rise_cnt++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_run = 1'b0;
    btn_step = 1'b0;
    halt = 1'b0;
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
  endtask

  task automatic enter_run();
    slow_auto = 1'b0;
    slow_clk = 1'b0;
    btn_run = 1'b1;
    repeat (20) cyc();
    btn_run = 1'b0;
    repeat (5) cyc();
  endtask

  task automatic test_reset();
    do_reset();
    slow_auto = 1'b1; slow_half = 8; slow_ctr = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      checks++;
      if ({proc_en, state, cycle_count, proc_en4, state4, cycle_count4} !== 25'd0) begin
        errors++;
        $display("FAIL reset cyc=%0d pen=%b st=%0d cnt=%0d need all zero", i, proc_en, state, cycle_count);
      end
    end
    slow_auto = 1'b0;
  endtask

  task automatic test_run();
    int pulses = 0;
    do_reset();
    enter_run();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL run_enter state=%0d need 1", state);
    end
    slow_clk = 1'b0; slow_auto = 1'b1; slow_half = 4; slow_ctr = 0; rise_cnt = 0;
    for (int i = 0; i < 200 && rise_cnt < 10; i++) begin
      cyc();
      pulses += int'(proc_en);
      checks++;
      if ({proc_en, state, cycle_count, proc_en4, state4, cycle_count4} !==
          {1'(m_pen), 2'(m_st), 16'(m_c16), 1'(m_pen), 2'(m_st), 4'(m_c4)}) begin
        errors++;
        $display("FAIL run cyc=%0d pen=%b/%0d st=%0d/%0d cnt=%0d/%0d", i, proc_en, m_pen, state, m_st, cycle_count, m_c16);
      end
    end
    slow_auto = 1'b0;
    repeat (6) begin
      cyc();
      pulses += int'(proc_en);
    end
    checks++;
    if (cycle_count !== 16'd10 || state !== 2'd1 || pulses != 10) begin
      errors++;
      $display("FAIL run_total cnt=%0d pulses=%0d st=%0d need 10 10 1", cycle_count, pulses, state);
    end
  endtask

  task automatic test_step();
    int pulses = 0;
    do_reset();
    slow_auto = 1'b0; slow_clk = 1'b0;
    btn_step = 1'b1;
    repeat (24) cyc();
    checks++;
    if (state !== 2'd2 || m_st != 2) begin
      errors++;
      $display("FAIL step_enter state=%0d need 2", state);
    end
    slow_auto = 1'b1; slow_half = 4; slow_ctr = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      pulses += int'(proc_en);
      checks++;
      if ({proc_en, state, cycle_count} !== {1'(m_pen), 2'(m_st), 16'(m_c16)}) begin
        errors++;
        $display("FAIL step cyc=%0d pen=%b/%0d st=%0d/%0d cnt=%0d/%0d", i, proc_en, m_pen, state, m_st, cycle_count, m_c16);
      end
    end
    slow_auto = 1'b0;
    btn_step = 1'b0;
    checks++;
    if (pulses != 1 || state !== 2'd0 || cycle_count !== 16'd1) begin
      errors++;
      $display("FAIL step_total pulses=%0d st=%0d cnt=%0d need 1 0 1", pulses, state, cycle_count);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    slow_auto = 1'b0; slow_clk = 1'b0;
    for (int i = 0; i < 100; i++) begin
      btn_run = ((i / 5) % 2 == 0);
      cyc();
      checks++;
      if (state !== 2'd0 || m_st != 0) begin
        errors++;
        $display("FAIL bounce cyc=%0d state=%0d need 0", i, state);
      end
    end
    btn_run = 1'b1;
    repeat (24) cyc();
    btn_run = 1'b0;
    checks++;
    if (state !== 2'd1 || m_st != 1) begin
      errors++;
      $display("FAIL bounce_hold state=%0d need 1", state);
    end
  endtask

  task automatic test_halt();
    bit found = 1'b0;
    do_reset();
    enter_run();
    slow_auto = 1'b1; slow_half = 4; slow_ctr = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc();
      if (m_sh2 == 1 && m_sh3 == 0 && m_c16 > 0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL halt_setup no tick found within 60 cycles");
    end
    halt = 1'b1;
    cyc();
    halt = 1'b0;
    checks++;
    if (proc_en !== 1'b0 || state !== 2'd3 || m_st != 3 || m_pen != 0) begin
      errors++;
      $display("FAIL halt_tick pen=%b st=%0d need 0 3", proc_en, state);
    end
    btn_run = 1'b1;
    repeat (22) cyc();
    btn_run = 1'b0;
    btn_step = 1'b1;
    repeat (22) cyc();
    btn_step = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      checks++;
      if (proc_en !== 1'b0 || state !== 2'd3 || state4 !== 2'd3) begin
        errors++;
        $display("FAIL halted cyc=%0d pen=%b st=%0d need 0 3", i, proc_en, state);
      end
    end
    slow_auto = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({proc_en, state, cycle_count, proc_en4, state4, cycle_count4} !== 25'd0) begin
      errors++;
      $display("FAIL halt_reset pen=%b st=%0d cnt=%0d need all zero", proc_en, state, cycle_count);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    do_reset();
    enter_run();
    slow_auto = 1'b1; slow_half = 3; slow_ctr = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      cyc();
      if (m_pen == 1 && m_c16 >= 2) found = 1'b1;
    end
    checks++;
    if (!found || proc_en !== 1'b1) begin
      errors++;
      $display("FAIL areset_setup pen=%b need 1", proc_en);
    end
    slow_auto = 1'b0;
    slow_clk = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({proc_en, state, cycle_count} !== 19'd0) begin
      errors++;
      $display("FAIL areset_mid pen=%b st=%0d cnt=%0d need all zero", proc_en, state, cycle_count);
    end
    @(negedge clk_in);
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if ({proc_en, state, cycle_count} !== {1'(m_pen), 2'(m_st), 16'(m_c16)} || proc_en !== 1'b0) begin
        errors++;
        $display("FAIL areset_after cyc=%0d pen=%b st=%0d cnt=%0d need 0 0 0", i, proc_en, state, cycle_count);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    enter_run();
    slow_clk = 1'b0; slow_auto = 1'b1; slow_half = 3; slow_ctr = 0; rise_cnt = 0;
    for (int i = 0; i < 300 && rise_cnt < 20; i++) cyc();
    slow_auto = 1'b0;
    repeat (6) cyc();
    checks++;
    if (cycle_count4 !== 4'd15 || cycle_count !== 16'd20) begin
      errors++;
      $display("FAIL saturate cnt4=%0d cnt16=%0d need 15 20", cycle_count4, cycle_count);
    end
  endtask

  task automatic test_random();
    int hr, hs;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      slow_clk = 1'b0;
      slow_half = $urandom_range(1, 6);
      slow_ctr = 0;
      slow_auto = 1'b1;
      hr = 0; hs = 0;
      for (int i = 0; i < 700; i++) begin
        if (--hr <= 0) begin
          btn_run = 1'($urandom_range(0, 1));
          hr = $urandom_range(1, 40);
        end
        if (--hs <= 0) begin
          btn_step = 1'($urandom_range(0, 1));
          hs = $urandom_range(1, 40);
        end
        halt = (seg >= 2) && ($urandom_range(0, 399) == 0);
        cyc();
        checks++;
        if ({proc_en, state, cycle_count, proc_en4, state4, cycle_count4} !==
            {1'(m_pen), 2'(m_st), 16'(m_c16), 1'(m_pen), 2'(m_st), 4'(m_c4)}) begin
          errors++;
          $display("FAIL random seg=%0d cyc=%0d pen=%b/%0d st=%0d/%0d cnt=%0d/%0d cnt4=%0d/%0d",
                   seg, i, proc_en, m_pen, state, m_st, cycle_count, m_c16, cycle_count4, m_c4);
        end
      end
      slow_auto = 1'b0;
      halt = 1'b0;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run();
    test_step();
    test_bounce();
    test_halt();
    test_async_reset();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
